// File: rtl/alu_pkg.sv
// Shared constants and state type for the ALU issue sequencer.
package alu_pkg;

   localparam int XLEN  = 32;
   localparam int WSHAM = $clog2(XLEN);

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } seq_state_e;

endpackage

// File: rtl/alu_seq.sv
// Issue-side sequencer: holds one op, iterates the multi-cycle ALU by feeding
// its result/remaining shift back, and presents the final result over valid/ready.
module alu_seq #(
   parameter int XLEN  = alu_pkg::XLEN,
   parameter int WSHAM = $clog2(XLEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [2:0]       in_f3,
   input  logic             in_arith,
   input  logic             in_shadd,
   input  logic             in_branch,
   output logic             alu_start,
   output logic [XLEN-1:0]  alu_src_a,
   output logic [XLEN-1:0]  alu_src_b,
   output logic [2:0]       alu_f3,
   output logic             alu_arith,
   output logic             alu_shadd,
   output logic             alu_branch,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [WSHAM-1:0] alu_shamt,
   input  logic             alu_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result
);

   import alu_pkg::*;

   seq_state_e      state_reg, state_next;
   logic [XLEN-1:0] a_reg, a_next;
   logic [XLEN-1:0] b_reg, b_next;
   logic [2:0]      f3_reg, f3_next;
   logic            arith_reg, arith_next;
   logic            shadd_reg, shadd_next;
   logic            branch_reg, branch_next;
   logic            first_reg, first_next;
   logic            out_valid_reg, out_valid_next;
   logic [XLEN-1:0] out_result_reg, out_result_next;

   logic accept;
   logic pure_shift;

   // flush masks in_ready so an op offered in the flush cycle is dropped
   assign in_ready   = !flush && ((state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready));
   assign accept     = in_valid && in_ready;
   assign pure_shift = !shadd_reg && !branch_reg && ((f3_reg == F3_SLL) || (f3_reg == F3_SR));

   assign alu_start  = (state_reg == S_RUN) && first_reg;
   assign alu_src_a  = a_reg;
   assign alu_src_b  = b_reg;
   assign alu_f3     = f3_reg;
   assign alu_arith  = arith_reg;
   assign alu_shadd  = shadd_reg;
   assign alu_branch = branch_reg;
   assign out_valid  = out_valid_reg;
   assign out_result = out_result_reg;

   always_comb begin
      state_next      = state_reg;
      a_next          = a_reg;
      b_next          = b_reg;
      f3_next         = f3_reg;
      arith_next      = arith_reg;
      shadd_next      = shadd_reg;
      branch_next     = branch_reg;
      first_next      = first_reg;
      out_valid_next  = out_valid_reg;
      out_result_next = out_result_reg;
      if (flush) begin
         state_next     = S_IDLE;
         out_valid_next = 1'b0;
         first_next     = 1'b0;
      end else begin
         case (state_reg)
            S_RUN: begin
               first_next = 1'b0;
               if (alu_ready) begin
                  out_result_next = alu_result;
                  out_valid_next  = 1'b1;
                  state_next      = S_DONE;
               end else begin
                  // partial result and remaining shift become next iteration's operands
                  a_next = alu_result;
                  if (pure_shift) begin
                     b_next[WSHAM-1:0] = alu_shamt;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_next = 1'b0;
                  state_next     = S_IDLE;
               end
            end
            default: ;
         endcase
         if (accept) begin
            a_next         = in_a;
            b_next         = in_b;
            f3_next        = in_f3;
            arith_next     = in_arith;
            shadd_next     = in_shadd;
            branch_next    = in_branch;
            first_next     = 1'b1;
            out_valid_next = 1'b0;
            state_next     = S_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         a_reg          <= '0;
         b_reg          <= '0;
         f3_reg         <= '0;
         arith_reg      <= 1'b0;
         shadd_reg      <= 1'b0;
         branch_reg     <= 1'b0;
         first_reg      <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_result_reg <= '0;
      end else begin
         state_reg      <= state_next;
         a_reg          <= a_next;
         b_reg          <= b_next;
         f3_reg         <= f3_next;
         arith_reg      <= arith_next;
         shadd_reg      <= shadd_next;
         branch_reg     <= branch_next;
         first_reg      <= first_next;
         out_valid_reg  <= out_valid_next;
         out_result_reg <= out_result_next;
      end
   end

endmodule
